io_input_port: RTL and testbench

- Memory-mapped input-port block for the pipelined computer; the read-side counterpart of the I/O output ports on the same data-memory bus.
- Samples three external 32-bit input ports (switches/keys) and synchronises each to io_clk.
- Debounces each port as a whole word and latches per-port sticky change flags.
- Returns port data or status to the CPU as a registered read, one io_clk cycle after the request.

---
 rtl/io_map_pkg.sv | 20 ++
 rtl/io_debounce.sv | 49 ++++
 rtl/io_input_port.sv | 78 +++++++
 tb/tb_io_input_port.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared data-memory I/O map: word-select codes (addr[7:2]) for the input and
// output port blocks, plus the input-port debounce default.
package io_map_pkg;

  typedef logic [31:0] io_word_t;
  typedef logic [5:0]  io_sel_t;

  // Output-port side of the same map, kept here so both directions stay disjoint.
  localparam io_sel_t IO_OUT0_ADDR    = 6'b100000;  // 0x80
  localparam io_sel_t IO_OUT1_ADDR    = 6'b100001;  // 0x84
  localparam io_sel_t IO_OUT2_ADDR    = 6'b100010;  // 0x88

  localparam io_sel_t IO_IN0_ADDR     = 6'b110000;  // 0xC0
  localparam io_sel_t IO_IN1_ADDR     = 6'b110001;  // 0xC4
  localparam io_sel_t IO_IN2_ADDR     = 6'b110010;  // 0xC8
  localparam io_sel_t IO_IN_STAT_ADDR = 6'b110011;  // 0xCC

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/io_debounce.sv
// One 32-bit input word: two-flop synchroniser, whole-word debounce and a
// single-cycle chg pulse coincident with each stable-value update.
module io_debounce
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic     io_clk,
  input  logic     resetn,
  input  io_word_t din,
  output io_word_t stable,
  output logic     chg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  io_word_t         sync_q1;
  io_word_t         sync_q2;
  io_word_t         cand;
  logic [CNT_W-1:0] cnt;
  logic             settled;

  // chg is decoded from registers only, so it is clean for the flag logic.
  assign settled = (sync_q2 == cand) && (cnt == CNT_MAX);
  assign chg     = settled && (cand != stable);

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      cand    <= '0;
      stable  <= '0;
      cnt     <= '0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      if (sync_q2 != cand) begin
        cand <= sync_q2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        if (cand != stable) stable <= cand;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped input ports: three debounced words, sticky change flags and a
// registered CPU read. Define IO_INPUT_IRQ_EN to add the io_irq output.
module io_input_port
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic        read_io_enable,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  input  logic [31:0] in_port2,
  output logic [31:0] io_read_data
`ifdef IO_INPUT_IRQ_EN
  ,
  output logic        io_irq
`endif
);

  io_word_t stable0, stable1, stable2;
  logic [2:0] chg;
  logic [2:0] flag_q;
  io_sel_t    word_sel;
  io_word_t   rd_mux;
  logic       stat_clear;
  logic       unused_addr_bits;

  assign word_sel         = addr[7:2];
  assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb0 (
    .io_clk(io_clk), .resetn(resetn), .din(in_port0), .stable(stable0), .chg(chg[0])
  );
  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb1 (
    .io_clk(io_clk), .resetn(resetn), .din(in_port1), .stable(stable1), .chg(chg[1])
  );
  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb2 (
    .io_clk(io_clk), .resetn(resetn), .din(in_port2), .stable(stable2), .chg(chg[2])
  );

  always_comb begin
    rd_mux = '0;
    case (word_sel)
      IO_IN0_ADDR:     rd_mux = stable0;
      IO_IN1_ADDR:     rd_mux = stable1;
      IO_IN2_ADDR:     rd_mux = stable2;
      IO_IN_STAT_ADDR: rd_mux = {29'b0, flag_q};
      default:         rd_mux = '0;
    endcase
  end

  // Read protocol: read_io_enable is a valid strobe with no ready (the port is
  // always ready); the decoded word is captured on the strobe edge and held in
  // io_read_data until the next strobe. A status read returns the old flags
  // and clears them on that same edge, but a coincident chg still sets its flag.
  assign stat_clear = read_io_enable && (word_sel == IO_IN_STAT_ADDR);

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      io_read_data <= '0;
      flag_q       <= '0;
    end else begin
      if (read_io_enable) io_read_data <= rd_mux;
      flag_q <= (flag_q & ~{3{stat_clear}}) | chg;
    end
  end

`ifdef IO_INPUT_IRQ_EN
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) io_irq <= 1'b0;
    else         io_irq <= |flag_q;
  end
`endif

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port (DEBOUNCE_CYCLES=16); covers the io_irq
// path too when built with IO_INPUT_IRQ_EN.
module tb_io_input_port;

  logic        io_clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic        read_io_enable;
  logic [31:0] in_port0, in_port1, in_port2;
  logic [31:0] io_read_data;
`ifdef IO_INPUT_IRQ_EN
  logic        io_irq;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  io_input_port #(.DEBOUNCE_CYCLES(16), .CNT_W(16)) dut (
    .io_clk(io_clk),
    .resetn(resetn),
    .addr(addr),
    .read_io_enable(read_io_enable),
    .in_port0(in_port0),
    .in_port1(in_port1),
    .in_port2(in_port2),
    .io_read_data(io_read_data)
`ifdef IO_INPUT_IRQ_EN
    ,
    .io_irq(io_irq)
`endif
  );

  // clock / reset
  always #5 io_clk = ~io_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge io_clk);
      #1;
    end
  endtask

  // strobe one read; expected value goes through the scoreboard queue
  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    addr           = a;
    read_io_enable = 1'b1;
    @(posedge io_clk);
    #1;
    read_io_enable = 1'b0;
    addr           = 32'h0;
    e = exp_q.pop_front();
    check(tag, io_read_data, e);
  endtask

`ifdef IO_INPUT_IRQ_EN
  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'b0, io_irq}, {31'b0, exp});
  endtask
`endif

  initial begin
    resetn         = 1'b0;
    addr           = 32'h0;
    read_io_enable = 1'b0;
    in_port0       = 32'hFFFF_FFFF;
    in_port1       = 32'h0;
    in_port2       = 32'h0;
    tick(4);

    // 1. reset, then full-latency acceptance of a value held through reset
    check("reset_read_data", io_read_data, 32'h0);
    resetn = 1'b1;
    do_read("stat_after_reset", 32'hCC, 32'h0);   // E1
    do_read("in0_early", 32'hC0, 32'h0);          // E2
    tick(16);                                     // E3..E18
    do_read("in0_edge19_old", 32'hC0, 32'h0);     // E19: stable updates here
`ifdef IO_INPUT_IRQ_EN
    check_irq("irq_not_yet", 1'b0);
`endif
    do_read("in0_accepted", 32'hC0, 32'hFFFF_FFFF);  // E20
`ifdef IO_INPUT_IRQ_EN
    check_irq("irq_set", 1'b1);
`endif
    do_read("stat_flag0", 32'hCC, 32'h1);         // E21 clears
`ifdef IO_INPUT_IRQ_EN
    check_irq("irq_still_high", 1'b1);
`endif
    do_read("stat_cleared", 32'hCC, 32'h0);       // E22
`ifdef IO_INPUT_IRQ_EN
    check_irq("irq_dropped", 1'b0);
`endif

    // 2. glitch shorter than the debounce window
    in_port1 = 32'h0000_00A5;
    tick(10);
    in_port1 = 32'h0;
    tick(25);
    do_read("glitch_in1", 32'hC4, 32'h0);
    do_read("glitch_stat", 32'hCC, 32'h0);

    // 3. read latency, unmapped address, hold without strobe
    in_port2 = 32'h1234_5678;
    tick(20);
    do_read("in2_value", 32'hC8, 32'h1234_5678);
    do_read("unmapped_d0", 32'hD0, 32'h0);
    do_read("stat_flag2", 32'hCC, 32'h4);
    addr = 32'hC8;
    tick(2);
    check("hold_no_strobe", io_read_data, 32'h4);
    addr = 32'h0;

    // 4. clear race: chg1 lands on the same edge as a status read
    in_port0 = 32'h0;        // chg0 at G19
    tick(5);
    in_port1 = 32'h0000_00C3; // chg1 at F19 = G24
    tick(18);
    do_read("race_returned", 32'hCC, 32'h1);
    do_read("race_flag1_kept", 32'hCC, 32'h2);
    do_read("race_stat_clear", 32'hCC, 32'h0);

    // 5. simultaneous change on ports 0 and 2
    in_port0 = 32'h5A5A_0001;
    in_port2 = 32'h0;
    tick(18);
    do_read("multi_coincident", 32'hCC, 32'h0);   // chg on this edge, set wins
    do_read("multi_stat", 32'hCC, 32'h5);
    do_read("multi_reread", 32'hCC, 32'h0);
    do_read("multi_in0", 32'hC0, 32'h5A5A_0001);
    do_read("multi_in2", 32'hC8, 32'h0);

    // 6. reset mid-debounce discards the candidate
    in_port1 = 32'hDEAD_BEEF;
    tick(8);
    resetn = 1'b0;
    tick(2);
    check("midreset_read_data", io_read_data, 32'h0);
    resetn = 1'b1;
    tick(17);                                        // E1..E17
    do_read("midreset_in1_e18", 32'hC4, 32'h0);      // E18
    do_read("midreset_in1_e19", 32'hC4, 32'h0);      // E19
    do_read("midreset_in1_e20", 32'hC4, 32'hDEAD_BEEF);
    do_read("midreset_stat", 32'hCC, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
